spike_rate_window: RTL and testbench
====================================

Name: spike_rate_window

Overview:
- Sliding-window firing-rate estimator for a spike counter's per-millisecond output, e.g. spike_count_neuron0 from the spike counter.
- Each enabled sim_clk edge (1 ms simulation time) stores the latest per-ms spike count in a circular buffer and keeps a running sum over the last W = 2^log2_win samples.
- Produces the window spike total and the rate in pps, both readable over wire-outs or usable as a rate input to downstream muscle/synapse stages.

Parameters:
- CNT_W, 32, width of the incoming spike count.
- SAMP_W, 8, stored sample width; input is saturated to 2^SAMP_W-1.
- LOG2_MAX, 7, log2 of maximum window depth (128 ms); physical buffer depth 2^LOG2_MAX.

Ports:
- sim_clk  in  1  simulation clock, 1 cycle per ms.
- reset_global  in  1  asynchronous, active-high reset.
- en  in  1  sample-enable; the sample is taken on sim_clk edges where en=1.
- clear  in  1  synchronous restart, also clears sat_flag.
- log2_win  in  4  window select; W = 2^min(log2_win, LOG2_MAX).
- spike_cnt_in  in  CNT_W  spikes counted in the last ms (unsigned).
- window_sum  out  SAMP_W+LOG2_MAX  sum of the last W samples.
- rate_pps  out  32  (window_sum*1000) >> log2_eff, truncated.
- rate_valid  out  1  high once W samples have been accumulated since the last restart.
- sat_flag  out  1  sticky; set when any sample saturated.

Behaviour:
- Reset (async) values:
  - window_sum=0, rate_pps=0, rate_valid=0, sat_flag=0.
  - wr_ptr=0, fill_cnt=0, state=FILL, latched log2_eff=min(log2_win, LOG2_MAX) captured at the first edge after reset.
  - Buffer contents don't-care; they are never read before being written.
- Priority per edge: clear > window change > en > hold.
- Window change: registered log2_eff differs from min(log2_win, LOG2_MAX).
  - Latch the new value; restart exactly as clear does, except sat_flag is preserved.
  - That cycle's sample is discarded.
- Restart (clear or window change):
  - window_sum=0, wr_ptr=0, fill_cnt=0, state=FILL.
  - rate_valid=0 and rate_pps=0 on the following edge.
- Sample: s = (spike_cnt_in > 2^SAMP_W-1) ? 2^SAMP_W-1 : spike_cnt_in[SAMP_W-1:0]. On saturation, sat_flag<=1.
- FILL state, en=1:
  - buf[wr_ptr]<=s; window_sum<=window_sum+s; fill_cnt++.
  - When fill_cnt==W-1 (this is the W-th sample), go to RUN.
- RUN state, en=1:
  - window_sum <= window_sum + s - buf[wr_ptr]; buf[wr_ptr]<=s.
  - buf is read before it is written in the same cycle (async-read register/distributed RAM).
- wr_ptr wraps from W-1 to 0, not at physical depth.
- en=0: all state holds; rate_pps keeps tracking window_sum.
- Rate pipeline (one register stage after window_sum):
  - rate_pps <= (window_sum*1000) >> log2_eff. The constant multiply uses shift-add, no DSP required.
  - rate_valid <= (state==RUN).
  - Net latency: sample edge n → window_sum at n+1 → rate_pps/rate_valid at n+2.
- Width: window_sum never overflows (max W*(2^SAMP_W-1) < 2^(SAMP_W+LOG2_MAX)). rate_pps max 255*1000 fits in 32 bits.
- W=1 (log2_win=0): FILL lasts one sample; in RUN window_sum equals the latest sample.
- Reset asserted mid-FILL or mid-RUN returns to reset values immediately (async). It is released synchronously to sim_clk by the upstream reset source.

Test Plan:
- Assert reset_global mid-run → all outputs 0 immediately; after release with en=0, outputs stay 0 for 10 cycles.
- log2_win=2, en=1, spike_cnt_in=3 constant → window_sum 3,6,9,12 on successive edges; one edge after the 12, rate_valid=1 and rate_pps=3000; thereafter window_sum stays 12.
- log2_win=2, inputs 1,2,3,4,5,0,0,0,0 → window_sum 1,3,6,10,14,12,9,5,0; rate_pps follows one edge later: 2500,3500,3000,2250,1250,0.
- spike_cnt_in=300 (SAMP_W=8) → stored sample 255, sat_flag=1 and held through later small inputs; clear=1 → sat_flag=0, window_sum=0, rate_valid=0.
- RUN with W=4, switch log2_win to 3 → next edge window_sum=0, then rate_valid=0; input 2 constant → rate_valid returns after 8 samples with window_sum=16, rate_pps=2000.
- log2_win=9 (> LOG2_MAX) → window behaves as W=128.
- Toggling en during FILL → fill_cnt advances only on en=1 edges.

Source files
------------

// File: rtl/spike_rate_window_if.sv
// Sample-in / rate-out bundle of the sliding-window rate estimator.
// master drives the per-ms sample and controls; slave (the estimator) returns the window results.
interface spike_rate_window_if #(
  parameter int CNT_W    = 32,
  parameter int SAMP_W   = 8,
  parameter int LOG2_MAX = 7
);
  logic                       en;
  logic                       clear;
  logic [3:0]                 log2_win;
  logic [CNT_W-1:0]           spike_cnt_in;
  logic [SAMP_W+LOG2_MAX-1:0] window_sum;
  logic [31:0]                rate_pps;
  logic                       rate_valid;
  logic                       sat_flag;

  modport master (
    output en, clear, log2_win, spike_cnt_in,
    input  window_sum, rate_pps, rate_valid, sat_flag
  );

  modport slave (
    input  en, clear, log2_win, spike_cnt_in,
    output window_sum, rate_pps, rate_valid, sat_flag
  );
endinterface

// File: rtl/spike_rate_window.sv
// Sliding-window spike-rate estimator: window_sum one edge after a sample, rate_pps/rate_valid one edge later.
// No backpressure: a sample is consumed on every sim_clk edge with en=1; en=0 freezes the window.
module spike_rate_window #(
  parameter int CNT_W    = 32,
  parameter int SAMP_W   = 8,
  parameter int LOG2_MAX = 7
) (
  input  logic               sim_clk,
  input  logic               reset_global,
  spike_rate_window_if.slave bus
);
  localparam int SUM_W = SAMP_W + LOG2_MAX;
  localparam int DEPTH = 1 << LOG2_MAX;
  localparam int SMAX  = (1 << SAMP_W) - 1;

  typedef enum logic {FILL, RUN} state_t;

  state_t              r_state;
  logic [SUM_W-1:0]    r_sum;
  logic [LOG2_MAX-1:0] r_wr_ptr;
  logic [LOG2_MAX-1:0] r_fill_cnt;
  logic [3:0]          r_log2_eff;
  logic                r_eff_vld;
  logic [31:0]         r_rate;
  logic                r_rate_vld;
  logic                r_sat;
  logic [SAMP_W-1:0]   r_buf [DEPTH];

  logic [3:0]          w_log2_req;
  logic [3:0]          w_log2_cur;
  logic                w_win_chg;
  logic                w_take;
  logic [LOG2_MAX-1:0] w_last;
  logic                w_sat;
  logic [SAMP_W-1:0]   w_samp;
  logic [SAMP_W-1:0]   w_old;
  logic [SUM_W-1:0]    w_sum_nxt;
  logic [31:0]         w_sum32;
  logic [31:0]         w_prod;
  logic [31:0]         w_rate;

  assign w_log2_req = (bus.log2_win > 4'(LOG2_MAX)) ? 4'(LOG2_MAX) : bus.log2_win;
  // Before the first edge after reset nothing is latched yet, so that edge uses the requested window directly.
  assign w_log2_cur = r_eff_vld ? r_log2_eff : w_log2_req;
  assign w_win_chg  = r_eff_vld && (r_log2_eff != w_log2_req);
  assign w_take     = bus.en && !bus.clear && !w_win_chg;
  assign w_last     = ~({LOG2_MAX{1'b1}} << w_log2_cur);

  assign w_sat  = bus.spike_cnt_in > CNT_W'(SMAX);
  assign w_samp = w_sat ? SAMP_W'(SMAX) : bus.spike_cnt_in[SAMP_W-1:0];
  assign w_old  = r_buf[r_wr_ptr];

  assign w_sum_nxt = (r_state == RUN) ? (r_sum + SUM_W'(w_samp) - SUM_W'(w_old))
                                      : (r_sum + SUM_W'(w_samp));

  // x*1000 = x*1024 - x*16 - x*8
  assign w_sum32 = 32'(r_sum);
  assign w_prod  = (w_sum32 << 10) - (w_sum32 << 4) - (w_sum32 << 3);
  assign w_rate  = w_prod >> r_log2_eff;

  always_ff @(posedge sim_clk or posedge reset_global) begin
    if (reset_global) begin
      r_state    <= FILL;
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_log2_eff <= '0;
      r_eff_vld  <= 1'b0;
      r_rate     <= '0;
      r_rate_vld <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_rate     <= w_rate;
      r_rate_vld <= (r_state == RUN);
      r_eff_vld  <= 1'b1;
      r_log2_eff <= w_log2_req;
      if (bus.clear || w_win_chg) begin
        r_state    <= FILL;
        r_sum      <= '0;
        r_wr_ptr   <= '0;
        r_fill_cnt <= '0;
        if (bus.clear) r_sat <= 1'b0;
      end else if (bus.en) begin
        if (w_sat) r_sat <= 1'b1;
        r_sum    <= w_sum_nxt;
        r_wr_ptr <= (r_wr_ptr == w_last) ? '0 : r_wr_ptr + 1'b1;
        if (r_state == FILL) begin
          r_fill_cnt <= r_fill_cnt + 1'b1;
          if (r_fill_cnt == w_last) r_state <= RUN;
        end
      end
    end
  end

  // Sample store is read combinationally above before this write lands.
  always_ff @(posedge sim_clk) begin
    if (w_take) r_buf[r_wr_ptr] <= w_samp;
  end

  assign bus.window_sum = r_sum;
  assign bus.rate_pps   = r_rate;
  assign bus.rate_valid = r_rate_vld;
  assign bus.sat_flag   = r_sat;
endmodule

// File: tb/tb_spike_rate_window.sv
// Table-driven bench for spike_rate_window with a scoreboard queue and hand-written reset sequences.
module tb_spike_rate_window;
  logic sim_clk = 1'b0;
  logic reset_global;

  spike_rate_window_if #(.CNT_W(32), .SAMP_W(8), .LOG2_MAX(7)) bus ();

  spike_rate_window #(.CNT_W(32), .SAMP_W(8), .LOG2_MAX(7)) dut (
    .sim_clk      (sim_clk),
    .reset_global (reset_global),
    .bus          (bus)
  );

  always #5 sim_clk = ~sim_clk;

  typedef struct {
    logic        clr;
    logic        en;
    logic [3:0]  lw;
    logic [31:0] cnt;
    logic [31:0] sum;
    logic [31:0] rate;
    logic        rv;
    logic        sat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void add(logic clr, logic en, logic [3:0] lw, logic [31:0] cnt,
                              logic [31:0] sum, logic [31:0] rate, logic rv, logic sat);
    vec_t v;
    v.clr = clr; v.en = en; v.lw = lw; v.cnt = cnt;
    v.sum = sum; v.rate = rate; v.rv = rv; v.sat = sat;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
  endtask

  task automatic chk_all(string nm, int idx, logic [31:0] s, logic [31:0] r, logic v, logic f);
    chk({nm, ".sum"},  idx, 32'(bus.window_sum), s);
    chk({nm, ".rate"}, idx, bus.rate_pps, r);
    chk({nm, ".rv"},   idx, 32'(bus.rate_valid), 32'(v));
    chk({nm, ".sat"},  idx, 32'(bus.sat_flag), 32'(f));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    reset_global     = 1'b1;
    bus.en           = 1'b0;
    bus.clear        = 1'b0;
    bus.log2_win     = 4'd2;
    bus.spike_cnt_in = '0;
    #1;
    chk_all("reset", 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge sim_clk);
    reset_global = 1'b0;
    repeat (2) @(negedge sim_clk);

    // W=4, constant 3
    add(0,1,2,3,  3,   0,0,0); add(0,1,2,3,  6, 750,0,0);
    add(0,1,2,3,  9,1500,0,0); add(0,1,2,3, 12,2250,0,0);
    add(0,1,2,3, 12,3000,1,0); add(0,1,2,3, 12,3000,1,0);
    // clear wins over en; rate stage still shows the pre-clear window
    add(1,1,2,7,  0,3000,1,0);
    // ramp then drain
    add(0,1,2,1,  1,   0,0,0); add(0,1,2,2,  3, 250,0,0);
    add(0,1,2,3,  6, 750,0,0); add(0,1,2,4, 10,1500,0,0);
    add(0,1,2,5, 14,2500,1,0); add(0,1,2,0, 12,3500,1,0);
    add(0,1,2,0,  9,3000,1,0); add(0,1,2,0,  5,2250,1,0);
    add(0,1,2,0,  0,1250,1,0); add(0,1,2,0,  0,   0,1,0);
    // saturation and sticky flag, cleared by clear
    add(1,0,2,0,    0,    0,1,0);
    add(0,1,2,300,255,    0,0,1); add(0,1,2,1,256,63750,0,1);
    add(0,1,2,1,  257,64000,0,1); add(1,1,2,300, 0,64250,0,0);
    add(0,0,2,0,    0,    0,0,0);
    // W=4 to RUN, then switch to W=8
    add(0,1,2,2, 2,   0,0,0); add(0,1,2,2, 4, 500,0,0);
    add(0,1,2,2, 6,1000,0,0); add(0,1,2,2, 8,1500,0,0);
    add(0,1,2,2, 8,2000,1,0);
    add(0,1,3,2, 0,2000,1,0);
    for (int k = 1; k <= 8; k++) add(0,1,3,2, 32'(2*k), 32'(250*(k-1)), 0,0);
    add(0,1,3,2, 16,2000,1,0);
    // W=2 with en toggled during FILL
    add(0,1,1,7, 0,2000,1,0);
    add(0,1,1,5, 5,   0,0,0); add(0,0,1,9, 5,2500,0,0);
    add(0,0,1,9, 5,2500,0,0); add(0,1,1,5,10,2500,0,0);
    add(0,0,1,9,10,5000,1,0); add(0,1,1,1, 6,5000,1,0);
    add(0,1,1,1, 2,3000,1,0);
    // W=1
    add(0,1,0,8, 0,1000,1,0); add(0,1,0,4, 4,   0,0,0);
    add(0,1,0,9, 9,4000,1,0); add(0,1,0,0, 0,9000,1,0);
    // log2_win beyond the maximum clamps to W=128
    add(0,1,9,5, 0,0,1,0);
    for (int k = 1; k <= 128; k++) add(0,1,9,1, 32'(k), 32'(((k-1)*1000) >> 7), 0,0);
    add(0,1,9,3,  130,1000,1,0); add(0,1,9,3,132,1015,1,0);
    add(0,1,9,300,386,1031,1,1);

    foreach (vecs[i]) begin
      @(negedge sim_clk);
      bus.clear        = vecs[i].clr;
      bus.en           = vecs[i].en;
      bus.log2_win     = vecs[i].lw;
      bus.spike_cnt_in = vecs[i].cnt;
      exp_q.push_back(vecs[i]);
      @(posedge sim_clk);
      #1;
      e = exp_q.pop_front();
      chk_all("vec", i, e.sum, e.rate, e.rv, e.sat);
    end

    // asynchronous reset mid-run, away from any edge
    @(negedge sim_clk);
    #2 reset_global = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 1'b0, 1'b0);
    @(negedge sim_clk);
    bus.en = 1'b0;
    bus.clear = 1'b0;
    reset_global = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge sim_clk);
      #1;
      chk_all("post_rst_idle", c, 0, 0, 1'b0, 1'b0);
    end
    @(negedge sim_clk);
    bus.en = 1'b1;
    bus.spike_cnt_in = 32'd4;
    @(posedge sim_clk);
    #1;
    chk_all("post_rst_sample", 0, 4, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
